// File: rtl/mcdf_formatter.sv
// Store-and-forward packet formatter sitting behind the MCDF arbiter.
// Pulls one package through id_req/ack, buffers it, then bursts it out framed by start/end.
module mcdf_formatter #(
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              a2f_val_i,
  input  logic [1:0]        a2f_id_i,
  input  logic [DATA_W-1:0] a2f_data_i,
  input  logic [2:0]        a2f_pkglen_sel_i,
  output logic              f2a_id_req_o,
  output logic              f2a_ack_o,
  input  logic              fmt_grant_i,
  output logic              fmt_req_o,
  output logic [1:0]        fmt_chid_o,
  output logic [5:0]        fmt_length_o,
  output logic [DATA_W-1:0] fmt_data_o,
  output logic              fmt_start_o,
  output logic              fmt_end_o,
  output logic              pkt_drop_o
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, ACK, RECV, SEND_REQ, SEND} state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] buf_mem [MAX_LEN];
  logic [5:0]        wr_cnt, rd_cnt, len_r, wr_next, rd_next;
  logic [TW-1:0]     timeout_cnt;
  logic [1:0]        chid_r;
  logic              wr_last, rd_last, time_up;

  function automatic logic [5:0] len_decode(input logic [2:0] sel);
    case (sel)
      3'd0:    len_decode = 6'd4;
      3'd1:    len_decode = 6'd8;
      3'd2:    len_decode = 6'd16;
      default: len_decode = 6'd32;
    endcase
  endfunction

  assign wr_next = wr_cnt + 6'd1;
  assign rd_next = rd_cnt + 6'd1;
  assign wr_last = a2f_val_i && (wr_next == len_r);
  assign rd_last = (rd_cnt == len_r - 6'd1);
  assign time_up = !a2f_val_i && (timeout_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     next_state = REQ;
      REQ:      next_state = ACK;
      ACK:      next_state = RECV;
      RECV: begin
        if (wr_last)      next_state = SEND_REQ;
        else if (time_up) next_state = IDLE;
      end
      SEND_REQ: if (fmt_grant_i) next_state = SEND;
      SEND:     if (rd_last) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Buffer contents need no reset: only a fully written package is ever read.
  always_ff @(posedge clk_i) begin
    if (state == RECV && a2f_val_i)
      buf_mem[wr_cnt[IW-1:0]] <= a2f_data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      timeout_cnt  <= '0;
      chid_r       <= '0;
      len_r        <= '0;
      f2a_id_req_o <= 1'b0;
      f2a_ack_o    <= 1'b0;
      fmt_req_o    <= 1'b0;
      fmt_chid_o   <= '0;
      fmt_length_o <= '0;
      fmt_data_o   <= '0;
      fmt_start_o  <= 1'b0;
      fmt_end_o    <= 1'b0;
      pkt_drop_o   <= 1'b0;
    end else begin
      state        <= next_state;
      f2a_id_req_o <= (next_state == REQ);
      f2a_ack_o    <= (next_state == ACK);
      fmt_req_o    <= (next_state == SEND_REQ);
      pkt_drop_o   <= 1'b0;
      fmt_data_o   <= '0;
      fmt_start_o  <= 1'b0;
      fmt_end_o    <= 1'b0;

      case (state)
        ACK: begin
          chid_r      <= a2f_id_i;
          len_r       <= len_decode(a2f_pkglen_sel_i);
          wr_cnt      <= '0;
          timeout_cnt <= '0;
        end
        RECV: begin
          if (a2f_val_i) begin
            wr_cnt      <= wr_next;
            timeout_cnt <= '0;
            if (wr_last) begin
              fmt_chid_o   <= chid_r;
              fmt_length_o <= len_r;
            end
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
            if (time_up)
              pkt_drop_o <= (wr_cnt != 6'd0);
          end
        end
        SEND_REQ: begin
          if (fmt_grant_i) begin
            rd_cnt      <= '0;
            fmt_data_o  <= buf_mem[0];
            fmt_start_o <= 1'b1;
            fmt_end_o   <= (len_r == 6'd1);
          end
        end
        SEND: begin
          // Output registers run one word ahead of rd_cnt so data lands the cycle after grant.
          if (!rd_last) begin
            rd_cnt     <= rd_next;
            fmt_data_o <= buf_mem[rd_next[IW-1:0]];
            fmt_end_o  <= (rd_next == len_r - 6'd1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mcdf_formatter.md
Name: mcdf_formatter

Overview:
- Downstream neighbour of the MCDF arbiter.
- Requests one package at a time from the arbiter through the id_req/ack handshake. It learns the channel id and package length, then stores the package's data words in an internal buffer.
- Once the whole package is stored, it sends it to the MCDF output interface as a framed burst (req/grant, start/end), one word per cycle.
- Store-and-forward: a package is emitted only after it has been fully received.

Parameters:
- DATA_W, 32, data word width.
- MAX_LEN, 32, buffer depth in words; equals the largest package length.
- TIMEOUT, 16, cycles allowed without an a2f_val_i beat while in RECV before the package is aborted.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- a2f_val_i  in  1  arbiter data valid, per word.
- a2f_id_i  in  2  channel id granted by the arbiter.
- a2f_data_i  in  DATA_W  arbiter data word.
- a2f_pkglen_sel_i  in  3  package length select of the granted channel.
- f2a_id_req_o  out  1  one-cycle pulse requesting arbitration.
- f2a_ack_o  out  1  one-cycle pulse that acknowledges the grant and latches id/length.
- fmt_grant_i  in  1  downstream grant.
- fmt_req_o  out  1  package ready; held until grant.
- fmt_chid_o  out  2  channel id of the package.
- fmt_length_o  out  6  package length in words (4..32).
- fmt_data_o  out  DATA_W  output data word.
- fmt_start_o  out  1  marks the first word of a package.
- fmt_end_o  out  1  marks the last word of a package.
- pkt_drop_o  out  1  one-cycle pulse when a partially received package is aborted.

Behaviour:
- All outputs are registered. While rstn_i=0, every output is 0, the state is IDLE and all counters are 0.
- Reset is asynchronous: asserting it mid-operation clears the state immediately and discards any buffered package.
- Length decode (evaluated when ack is issued):
  - pkglen_sel 0 -> 4 words
  - 1 -> 8
  - 2 -> 16
  - 3..7 -> 32
- FSM states: IDLE, REQ, ACK, RECV, SEND_REQ, SEND.
- IDLE:
  - Lasts exactly one cycle.
  - Next state is REQ.
- REQ:
  - f2a_id_req_o=1 for this single cycle.
  - Next state is ACK.
- ACK:
  - f2a_ack_o=1 for this single cycle.
  - a2f_id_i and the decoded length are latched into chid_r and len_r.
  - wr_cnt and timeout_cnt are cleared.
  - Next state is RECV.
- RECV:
  - Each cycle with a2f_val_i=1 writes a2f_data_i to buf[wr_cnt], increments wr_cnt and clears timeout_cnt.
  - Each cycle with a2f_val_i=0 increments timeout_cnt.
  - When the write makes wr_cnt reach len_r, next state is SEND_REQ. Any a2f_val_i beat after that is ignored.
  - When timeout_cnt reaches TIMEOUT, the package is aborted and the next state is IDLE.
    - pkt_drop_o pulses for 1 cycle only if wr_cnt>0 (a partial package was discarded).
    - If wr_cnt=0 (the arbiter had nothing to send), the abort is silent.
- a2f_val_i and a2f_data_i are ignored in every state except RECV.
- SEND_REQ:
  - fmt_req_o=1, fmt_chid_o=chid_r, fmt_length_o=len_r, all held stable.
  - On the first cycle with fmt_grant_i=1: fmt_req_o drops at the next edge, rd_cnt is cleared and the next state is SEND.
  - fmt_grant_i is ignored in all other states.
- SEND:
  - One word per cycle, no gaps, no backpressure.
  - fmt_data_o=buf[rd_cnt].
  - fmt_start_o=1 when rd_cnt=0.
  - fmt_end_o=1 when rd_cnt=len_r-1.
  - For length 1, start and end would coincide; this cannot occur because the minimum length is 4.
  - After the end word, next state is IDLE. fmt_data_o, fmt_start_o and fmt_end_o return to 0.
- Latency:
  - The first fmt_data_o word appears on the cycle after the edge at which fmt_grant_i=1 is sampled.
  - IDLE-to-IDLE minimum for an N-word package is N+N+4 cycles, plus any grant wait.
- Counter widths: wr_cnt and rd_cnt are 6 bits. wr_cnt never exceeds len_r, so there is no wrap-around.
- The buffer has no full/empty flags: a single package occupies it at a time, and only a complete package is read out.

Test Plan:
1. Basic 8-word package. id=1, pkglen_sel=1, 8 contiguous val beats of distinct data; grant raised 3 cycles after fmt_req_o.
   -> fmt_req_o high with chid=1 and length=8 until grant.
   -> 8 consecutive data words in input order, start on word 0, end on word 7.
   -> f2a_id_req_o and f2a_ack_o each seen exactly once.
2. Grant already high. pkglen_sel=0, id=2, fmt_grant_i tied high.
   -> fmt_req_o lasts 1 cycle.
   -> 4 words follow with start and end correct.
   -> the next f2a_id_req_o pulse comes 2 cycles after end (IDLE, then REQ).
3. Gapped input. pkglen_sel=1; 3 beats, a 5-cycle gap, then 5 beats.
   -> the package completes normally with length=8 and data in order.
   -> pkt_drop_o stays 0.
4. Timeouts, with TIMEOUT=16.
   -> No val after ack: return to IDLE after 16 cycles, with no fmt_req_o and no pkt_drop_o.
   -> 2 beats then silence: pkt_drop_o pulses once, and no fmt output is produced.
5. Length saturation. pkglen_sel=3'b101.
   -> fmt_length_o=32 and 32 words are emitted.
   -> A 33rd val beat presented after the 32nd is ignored.
6. Reset mid-operation. Assert rstn_i low during SEND, word 3 of 8.
   -> All outputs go to 0 immediately, without waiting for a clock.
   -> After release, the sequence restarts with REQ and no residual data appears.
